shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Command front-end placed directly upstream of shift_register.
//   Accepts a {data, shift count, fill bit} command over a valid/ready handshake.
//   Drives shift_register's load_en, parallel_in, shift_en and serial_in for exactly one load then N shifts.
//   Captures the resulting q and presents it on a valid/ready result port.
// PARAMETERS
//   WIDTH  8  data width; must match shift_register width
//   CNT_W  4  width of cmd_shifts; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk           in   1      rising-edge clock, shared with shift_register
//   rst_n         in   1      asynchronous, active-low reset
//   cmd_valid     in   1      command present
//   cmd_ready     out  1      sequencer can accept a command (high only in IDLE)
//   cmd_data      in   WIDTH  value to parallel-load
//   cmd_shifts    in   CNT_W  number of shift cycles N requested
//   cmd_fill      in   1      bit driven on serial_in during every shift
//   sr_q          in   WIDTH  q output of shift_register
//   load_en       out  1      to shift_register
//   shift_en      out  1      to shift_register
//   parallel_in   out  WIDTH  to shift_register
//   serial_in     out  1      to shift_register
//   busy          out  1      high in any state other than IDLE
//   result_valid  out  1      result_data valid
//   result_ready  in   1      consumer takes result
//   result_data   out  WIDTH  captured sr_q
// BEHAVIOUR
//   Reset (rst_n low, async)
//     - State = IDLE.
//     - load_en, shift_en, serial_in, result_valid = 0; parallel_in, result_data = 0; count = 0.
//     - Reset mid-command abandons it. shift_register contents are not restored.
//   Accept
//     - Accept on the rising edge where cmd_valid && cmd_ready.
//     - At accept, latch cmd_data, cmd_fill and N = min(cmd_shifts, WIDTH). Inputs are don't-care afterwards.
//   FSM: IDLE -> LOAD -> SHIFT -> CAPTURE -> DONE -> IDLE
//     - IDLE: cmd_ready = 1. Go to LOAD on accept.
//     - LOAD (1 cycle): load_en = 1 and parallel_in = latched data.
//       - Next state is SHIFT if N > 0, else CAPTURE.
//     - SHIFT (exactly N cycles): shift_en = 1 and serial_in = latched fill. Down-counter decrements each cycle.
//       - Go to CAPTURE when the counter reaches 1.
//     - CAPTURE (1 cycle): sr_q reflects the final shift/load. Register sr_q into result_data on the exit edge.
//     - DONE: result_valid = 1. result_data is held stable.
//       - Return to IDLE on the edge with result_ready = 1.
//       - If result_ready stays low, stall indefinitely.
//   Output decode
//     - load_en, shift_en and serial_in are decoded from the registered state only, never from inputs.
//     - load_en and shift_en are never high together.
//     - Outside LOAD, parallel_in holds the last latched data (0 after reset).
//   Latency
//     - result_valid rises N+2 edges after the accept edge.
//     - Back-to-back commands: a new accept can occur no earlier than one cycle after DONE exits (IDLE cycle).
//   Boundaries
//     - N = 0: load only; result = cmd_data.
//     - cmd_shifts > WIDTH: clamped to WIDTH.
//     - cmd_valid held high in non-IDLE states is ignored (cmd_ready = 0), not queued.
//     - result_ready high before DONE has no effect.
// TESTING
//   The bench instantiates shift_register, which shifts as q <= {q[WIDTH-2:0], serial_in}.
//   1. Reset: rst_n = 0 asynchronously mid-SHIFT
//      -> all outputs 0 immediately, state IDLE, cmd_ready = 1 after release.
//   2. cmd_data = 8'hAA, N = 5, fill = 1
//      -> 1 load_en pulse, 5 shift_en cycles, result_data = 8'h5F, result_valid at accept + 7 edges.
//   3. cmd_data = 8'h3C, N = 0
//      -> no shift_en pulse, result_data = 8'h3C, result_valid at accept + 2 edges.
//   4. cmd_data = 8'hFF, N = 12, fill = 0
//      -> clamped to 8 shift_en cycles, result_data = 8'h00.
//   5. result_ready held low 4 cycles in DONE
//      -> result_valid and result_data stable, cmd_ready = 0, a presented command is not accepted.
//   6. Two commands back-to-back with cmd_valid held high
//      -> second accepted only in the IDLE cycle after the first result handshake.
//      -> load_en and shift_en never high together.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: command front-end for shift_register.
// Takes a {data, shift count, fill} command, drives one parallel load followed
// by N shifts into the downstream shift_register, then returns the captured q
// on a valid/ready result port.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_shifts,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] sr_q,
  output logic             load_en,
  output logic             shift_en,
  output logic [WIDTH-1:0] parallel_in,
  output logic             serial_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] n_clamped;
  logic             accept;

  assign accept    = cmd_valid && cmd_ready;
  assign n_clamped = (cmd_shifts > MAX_N) ? MAX_N : cmd_shifts;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one load, N shifts, one capture, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = (count != '0) ? SHIFT : CAPTURE;
      SHIFT:   if (count <= CNT_W'(1)) state_next = CAPTURE;
      CAPTURE: state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, shift down-counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      fill_q   <= 1'b0;
      count    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        data_q <= cmd_data;
        fill_q <= cmd_fill;
        count  <= n_clamped;
      end else if (state == SHIFT) begin
        count <= count - CNT_W'(1);
      end
      if (state == CAPTURE) begin
        result_q <= sr_q;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    cmd_ready    = 1'b0;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    serial_in    = 1'b0;
    result_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:    cmd_ready    = 1'b1;
      LOAD:    load_en      = 1'b1;
      SHIFT: begin
        shift_en  = 1'b1;
        serial_in = fill_q;
      end
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  assign parallel_in = data_q;
  assign result_data = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving a behavioural shift_register.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_shifts;
  logic             cmd_fill;
  logic [WIDTH-1:0] sr_q = '0;
  logic             load_en;
  logic             shift_en;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] shifts;
    logic             fill;
    logic [WIDTH-1:0] exp;
    int               exp_n;
    int               stall;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  // Downstream shift_register model.
  always @(posedge clk) begin
    if (load_en)       sr_q <= parallel_in;
    else if (shift_en) sr_q <= {sr_q[WIDTH-2:0], serial_in};
  end

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_shifts   (cmd_shifts),
    .cmd_fill     (cmd_fill),
    .sr_q         (sr_q),
    .load_en      (load_en),
    .shift_en     (shift_en),
    .parallel_in  (parallel_in),
    .serial_in    (serial_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_wait", 32'(got), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    int  k      = 0;
    int  loads  = 0;
    int  shifts = 0;
    bit  seen   = 1'b0;
    logic [WIDTH-1:0] held;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_data   = v.data;
    cmd_shifts = v.shifts;
    cmd_fill   = v.fill;
    wait_ready();
    @(negedge clk);
    // Inputs are don't-care after accept; scramble them.
    cmd_valid  = 1'b0;
    cmd_data   = ~v.data;
    cmd_shifts = 4'(v.shifts + 4'd3);
    cmd_fill   = ~v.fill;
    for (int i = 0; i < 40; i++) begin
      loads  += int'(load_en);
      shifts += int'(shift_en);
      check("overlap", 32'(load_en & shift_en), 32'd0);
      if (load_en) check("parallel_in", 32'(parallel_in), 32'(v.data));
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("result_seen", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(v.exp_n + 2));
    check("load_pulses", 32'(loads), 32'd1);
    check("shift_cycles", 32'(shifts), 32'(v.exp_n));
    check("result_data", 32'(result_data), 32'(v.exp));
    check("done_not_ready", 32'(cmd_ready), 32'd0);
    held = result_data;
    for (int i = 0; i < v.stall; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 8'h11;
      @(negedge clk);
      check("stall_valid", 32'(result_valid), 32'd1);
      check("stall_data", 32'(result_data), 32'(held));
      check("stall_ready", 32'(cmd_ready), 32'd0);
      check("stall_no_load", 32'(load_en), 32'd0);
    end
    cmd_valid    = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("post_valid", 32'(result_valid), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [9:0] exp_ready;
    logic [9:0] exp_load;
    logic [9:0] exp_shift;
    logic [9:0] exp_valid;

    vecs[0] = '{8'hAA, 4'd5,  1'b1, 8'h5F, 5, 0};
    vecs[1] = '{8'h3C, 4'd0,  1'b0, 8'h3C, 0, 0};
    vecs[2] = '{8'hFF, 4'd12, 1'b0, 8'h00, 8, 0};
    vecs[3] = '{8'h81, 4'd3,  1'b1, 8'h0F, 3, 4};
    vecs[4] = '{8'hA5, 4'd4,  1'b0, 8'h50, 4, 0};
    vecs[5] = '{8'hC3, 4'd8,  1'b1, 8'hFF, 8, 0};
    vecs[6] = '{8'h00, 4'd15, 1'b1, 8'hFF, 8, 2};
    vecs[7] = '{8'h81, 4'd1,  1'b0, 8'h02, 1, 0};

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    cmd_shifts   = '0;
    cmd_fill     = 1'b0;
    result_ready = 1'b0;
    #2;
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_shift_en", 32'(shift_en), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result_data", 32'(result_data), 32'd0);
    check("rst_parallel_in", 32'(parallel_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_cmd(vecs[i]);

    // Async reset in the middle of a shift sequence.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_data   = 8'hF0;
    cmd_shifts = 4'd8;
    cmd_fill   = 1'b1;
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_shift_en", 32'(shift_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_shift_en", 32'(shift_en), 32'd0);
    check("arst_serial_in", 32'(serial_in), 32'd0);
    check("arst_load_en", 32'(load_en), 32'd0);
    check("arst_parallel_in", 32'(parallel_in), 32'd0);
    check("arst_result_data", 32'(result_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_result_valid", 32'(result_valid), 32'd0);

    // Back-to-back with cmd_valid and result_ready held high throughout.
    exp_ready = 10'h021;
    exp_load  = 10'h042;
    exp_shift = 10'h084;
    exp_valid = 10'h210;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_data     = 8'h81;
    cmd_shifts   = 4'd1;
    cmd_fill     = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("b2b_ready", 32'(cmd_ready), 32'(exp_ready[i]));
      check("b2b_load", 32'(load_en), 32'(exp_load[i]));
      check("b2b_shift", 32'(shift_en), 32'(exp_shift[i]));
      check("b2b_valid", 32'(result_valid), 32'(exp_valid[i]));
      check("b2b_overlap", 32'(load_en & shift_en), 32'd0);
      if (exp_valid[i]) check("b2b_data", 32'(result_data), 32'h02);
      @(negedge clk);
    end
    cmd_valid    = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
